// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Owns a 4-entry register bank and drives an external combinational add/sub
// ALU. Instructions are taken one at a time, and each one runs through three
// states: IDLE (accept), EXEC (ALU evaluates), DONE (result written, done).
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid && instr_ready. instr_ready is high only in IDLE and only
// while rst_n is high. The op/rx/ry/imm fields are sampled on that edge
// only. Any changes while the sequencer is busy are ignored.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   instr_valid/ready     instruction handshake
//   op, rx, ry, imm       instruction fields (00 LOAD, 01 MOVE, 10 ADD, 11 SUB)
//   alu_in1/in2/addsub    registered ALU operands and select (1 = add)
//   alu_out               combinational ALU result
//   done                  one-cycle pulse after write-back
//   zero                  last written result was zero
//   rd_sel, rd_data       combinational observation read of the bank
// ---------------------------------------------------------------------------
module alu_sequencer #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         instr_valid,
   output logic         instr_ready,
   input  logic [1:0]   op,
   input  logic [1:0]   rx,
   input  logic [1:0]   ry,
   input  logic [N-1:0] imm,
   output logic [N-1:0] alu_in1,
   output logic [N-1:0] alu_in2,
   output logic         alu_addsub,
   input  logic [N-1:0] alu_out,
   output logic         done,
   output logic         zero,
   input  logic [1:0]   rd_sel,
   output logic [N-1:0] rd_data
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_MOVE = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_SUB  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   state_t       state_next;
   logic [N-1:0] regs [4];
   logic [1:0]   dest;

   // Operand values selected from the current instruction fields; they are
   // only captured into alu_in1/alu_in2/alu_addsub on an accept edge.
   logic [N-1:0] sel_in1;
   logic [N-1:0] sel_in2;
   logic         sel_addsub;
   logic         accept;

   // Every op goes through the ALU: LOAD and MOVE are "x + 0".
   always_comb begin
      sel_in1    = '0;
      sel_in2    = '0;
      sel_addsub = 1'b1;
      case (op)
         OP_LOAD: sel_in1 = imm;
         OP_MOVE: sel_in1 = regs[ry];
         OP_ADD: begin
            sel_in1 = regs[rx];
            sel_in2 = regs[ry];
         end
         OP_SUB: begin
            sel_in1    = regs[rx];
            sel_in2    = regs[ry];
            sel_addsub = 1'b0;
         end
         default: ;
      endcase
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_next  = state;
      instr_ready = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = rst_n;
            if (instr_valid) state_next = EXEC;
         end
         EXEC: state_next = DONE;
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = instr_ready && instr_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         dest       <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_addsub <= 1'b0;
         zero       <= 1'b0;
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            dest       <= rx;
            alu_in1    <= sel_in1;
            alu_in2    <= sel_in2;
            alu_addsub <= sel_addsub;
         end
         // Write-back happens on the edge leaving EXEC, so the result is
         // readable during the DONE cycle.
         if (state == EXEC) begin
            regs[dest] <= alu_out;
            zero       <= (alu_out == '0);
         end
      end
   end

   assign rd_data = regs[rd_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Drives alu_sequencer with directed and random instructions. A plain
// add/sub ALU is modelled next to the DUT. Expected register contents come
// from an array model that applies each opcode's arithmetic directly.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

   localparam int N = 8;
   localparam logic [1:0] LOAD = 2'b00;
   localparam logic [1:0] MOVE = 2'b01;
   localparam logic [1:0] ADD  = 2'b10;
   localparam logic [1:0] SUB  = 2'b11;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         instr_valid = 1'b0;
   logic         instr_ready;
   logic [1:0]   op = '0;
   logic [1:0]   rx = '0;
   logic [1:0]   ry = '0;
   logic [N-1:0] imm = '0;
   logic [N-1:0] alu_in1;
   logic [N-1:0] alu_in2;
   logic         alu_addsub;
   logic [N-1:0] alu_out;
   logic         done;
   logic         zero;
   logic [1:0]   rd_sel = '0;
   logic [N-1:0] rd_data;

   always #5 clk = ~clk;

   // The external combinational ALU.
   assign alu_out = alu_addsub ? (alu_in1 + alu_in2) : (alu_in1 - alu_in2);

   alu_sequencer #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .op          (op),
      .rx          (rx),
      .ry          (ry),
      .imm         (imm),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_addsub  (alu_addsub),
      .alu_out     (alu_out),
      .done        (done),
      .zero        (zero),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data)
   );

   // ---------------- scoreboard ----------------
   int           n_checks = 0;
   int           n_fails  = 0;
   logic [N-1:0] model_r [4];
   logic         model_zero;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) model_r[i] = '0;
      model_zero = 1'b0;
   endtask

   task automatic check_bank();
      for (int i = 0; i < 4; i++) begin
         rd_sel = 2'(i);
         #1;
         check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(model_r[i]));
      end
   endtask

   task automatic check_reg(input string tag, input logic [1:0] idx, input logic [N-1:0] exp);
      rd_sel = idx;
      #0.5;
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic scramble_fields();
      op  = 2'($urandom);
      rx  = 2'($urandom);
      ry  = 2'($urandom);
      imm = N'($urandom);
   endtask

   // ---------------- driver ----------------
   // Entered 1ns after an edge with the DUT in IDLE; returns 1ns after the
   // edge that brings it back to IDLE (3 cycles per instruction).
   task automatic issue(input logic [1:0] o, input logic [1:0] x, input logic [1:0] y,
                        input logic [N-1:0] v, input bit keep_valid);
      logic [N-1:0] e1, e2, res;
      logic         eas;
      e1 = '0; e2 = '0; eas = 1'b1; res = '0;
      case (o)
         LOAD: begin e1 = v;          res = v; end
         MOVE: begin e1 = model_r[y]; res = model_r[y]; end
         ADD:  begin e1 = model_r[x]; e2 = model_r[y]; res = N'(int'(model_r[x]) + int'(model_r[y])); end
         default: begin
            e1 = model_r[x]; e2 = model_r[y]; eas = 1'b0;
            res = N'(int'(model_r[x]) - int'(model_r[y]) + 256);
         end
      endcase
      check("ready_in_idle", 32'(instr_ready), 32'd1);
      op = o; rx = x; ry = y; imm = v; instr_valid = 1'b1;

      @(posedge clk); #1;   // accept edge passed: EXEC
      check("alu_in1", 32'(alu_in1), 32'(e1));
      check("alu_in2", 32'(alu_in2), 32'(e2));
      check("alu_addsub", 32'(alu_addsub), 32'(eas));
      check("ready_in_exec", 32'(instr_ready), 32'd0);
      check("done_in_exec", 32'(done), 32'd0);
      scramble_fields();
      instr_valid = 1'($urandom);

      @(posedge clk); #1;   // write-back edge passed: DONE
      model_r[x] = res;
      model_zero = (res == '0);
      check("done_pulse", 32'(done), 32'd1);
      check("ready_in_done", 32'(instr_ready), 32'd0);
      check("zero_flag", 32'(zero), 32'(model_zero));
      check_bank();
      scramble_fields();
      instr_valid = keep_valid;

      @(posedge clk); #1;   // back in IDLE, no accept on the DONE edge
      check("done_cleared", 32'(done), 32'd0);
      check("alu_in1_hold", 32'(alu_in1), 32'(e1));
   endtask

   task automatic idle_cycles(input int n);
      logic [N-1:0] held;
      held = alu_in1;
      instr_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         scramble_fields();
         @(posedge clk); #1;
         check("idle_ready", 32'(instr_ready), 32'd1);
         check("idle_done", 32'(done), 32'd0);
         check("idle_in1_hold", 32'(alu_in1), 32'(held));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();

      // Reset then idle.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("ready_in_reset", 32'(instr_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      check("ready_after_reset", 32'(instr_ready), 32'd1);
      check("done_after_reset", 32'(done), 32'd0);
      check("zero_after_reset", 32'(zero), 32'd0);
      check("addsub_after_reset", 32'(alu_addsub), 32'd0);
      check_bank();

      // Basic add.
      issue(LOAD, 2'd1, 2'd0, 8'h05, 1'b0);
      issue(LOAD, 2'd2, 2'd3, 8'h03, 1'b0);
      issue(ADD,  2'd1, 2'd2, 8'h77, 1'b0);
      check_reg("add_R1_is_08", 2'd1, 8'h08);
      check("add_zero_0", 32'(zero), 32'd0);

      // Subtract to zero, then wrap below zero.
      issue(SUB, 2'd2, 2'd2, 8'h00, 1'b0);
      check_reg("sub_self_R2_is_00", 2'd2, 8'h00);
      check("sub_self_zero_1", 32'(zero), 32'd1);
      issue(SUB, 2'd2, 2'd1, 8'h00, 1'b0);
      check_reg("sub_wrap_R2_is_F8", 2'd2, 8'hF8);

      // Overflow wrap and MOVE.
      issue(LOAD, 2'd0, 2'd0, 8'hFF, 1'b0);
      issue(LOAD, 2'd3, 2'd0, 8'h01, 1'b0);
      issue(ADD,  2'd0, 2'd3, 8'h00, 1'b0);
      check_reg("ovf_R0_is_00", 2'd0, 8'h00);
      check("ovf_zero_1", 32'(zero), 32'd1);
      issue(MOVE, 2'd3, 2'd0, 8'h5A, 1'b0);
      check_reg("move_R3_is_00", 2'd3, 8'h00);
      idle_cycles(3);

      // Back-to-back with instr_valid held high.
      for (int i = 0; i < 8; i++)
         issue(2'($urandom), 2'($urandom), 2'($urandom), N'($urandom), 1'b1);

      // Reset in the middle of an instruction.
      idle_cycles(1);
      op = LOAD; rx = 2'd1; ry = 2'd0; imm = 8'hAA; instr_valid = 1'b1;
      @(posedge clk); #1;
      check("midop_accepted_in1", 32'(alu_in1), 32'hAA);
      rst_n = 1'b0;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      model_reset();
      check("midop_done", 32'(done), 32'd0);
      check("midop_ready_low", 32'(instr_ready), 32'd0);
      check("midop_in1", 32'(alu_in1), 32'd0);
      check("midop_zero", 32'(zero), 32'd0);
      rst_n = 1'b1;
      #0.5;
      check("midop_ready_after", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      check("midop_no_late_done", 32'(done), 32'd0);
      check_bank();

      // Random instruction stream.
      for (int i = 0; i < 80; i++) begin
         bit kv;
         kv = 1'($urandom);
         issue(2'($urandom), 2'($urandom), 2'($urandom), N'($urandom_range(0, 255)), kv);
         if (!kv) idle_cycles($urandom_range(0, 2));
      end
      instr_valid = 1'b0;
      idle_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
